// File: rtl/systemizer_driver_pkg.sv
// Shared definitions for the systemizer driver: FSM encoding and memory sizing helpers.
package systemizer_driver_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    function automatic int words_f(input int n, input int l, input int k);
        return (l * k) / n;
    endfunction

    // Address width for a memory of 'words' entries; never narrower than one bit.
    function automatic int aw_f(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO buffering systemizer read data ahead of the result stream.
module skid_fifo2 #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    assign w_pop   = i_pop && o_valid;

    // The producer never pushes into a full FIFO, so no overflow guard is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/systemizer_driver.sv
// Streams a matrix into the systemizer memory, starts it, waits for completion
// and streams the result back out through a two-entry output FIFO.
module systemizer_driver
    import systemizer_driver_pkg::*;
#(
    parameter  int N       = 20,
    parameter  int M       = 1,
    parameter  int L       = 200,
    parameter  int K       = 400,
    parameter  int TIMEOUT = 2**20,
    localparam int D       = N * M,
    localparam int WORDS   = words_f(N, L, K),
    localparam int AW      = aw_f(WORDS),
    localparam int TW      = aw_f(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          job_start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [D-1:0]  in_data,
    output logic          sys_start,
    output logic          sys_wr_en,
    output logic [AW-1:0] sys_wr_addr,
    output logic [D-1:0]  sys_data_in,
    output logic          sys_rd_en,
    output logic [AW-1:0] sys_rd_addr,
    input  logic [D-1:0]  sys_data_out,
    input  logic          sys_success,
    input  logic          sys_fail,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [D-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          job_ok,
    output logic          job_fail,
    output logic          timeout
);

    state_t        r_state, w_next;
    logic [AW-1:0] r_wr_cnt, r_rd_cnt;
    logic [TW-1:0] r_cyc;
    logic          r_rd_done, r_rd_pend, r_rd_last_pend;
    logic          r_job_ok, r_job_fail, r_timeout;

    logic          w_beat, w_wr_last, w_rd_last, w_rd_issue, w_to, w_pop, w_pop_last;
    logic          w_fifo_valid;
    logic [1:0]    w_fifo_cnt;
    logic [D:0]    w_fifo_data;

    assign w_beat     = (r_state == S_LOAD) && in_valid;
    assign w_wr_last  = (r_wr_cnt == AW'(WORDS - 1));
    assign w_rd_last  = (r_rd_cnt == AW'(WORDS - 1));
    assign w_to       = (r_state == S_WAIT) && !sys_fail && !sys_success
                        && (r_cyc == TW'(TIMEOUT - 1));
    assign w_pop      = w_fifo_valid && out_ready;
    assign w_pop_last = w_pop && w_fifo_data[D];
    // A word popped this cycle frees its slot in time for the read issued now.
    assign w_rd_issue = (r_state == S_UNLOAD) && !r_rd_done
                        && (({1'b0, w_fifo_cnt} + {2'b0, r_rd_pend}) < (3'd2 + {2'b0, w_pop}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (job_start) w_next = S_LOAD;
            S_LOAD:   if (w_beat && w_wr_last) w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT: begin
                if (sys_fail || w_to) w_next = S_FINISH;
                else if (sys_success) w_next = S_UNLOAD;
            end
            S_UNLOAD: if (w_pop_last) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_cyc          <= '0;
            r_rd_done      <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_last_pend <= 1'b0;
            r_job_ok       <= 1'b0;
            r_job_fail     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_rd_pend      <= w_rd_issue;
            r_rd_last_pend <= w_rd_issue && w_rd_last;
            case (r_state)
                S_IDLE: if (job_start) begin
                    r_wr_cnt   <= '0;
                    r_rd_cnt   <= '0;
                    r_cyc      <= '0;
                    r_rd_done  <= 1'b0;
                    r_job_ok   <= 1'b0;
                    r_job_fail <= 1'b0;
                    r_timeout  <= 1'b0;
                end
                S_LOAD:  if (w_beat && !w_wr_last) r_wr_cnt <= r_wr_cnt + 1'b1;
                S_START: r_cyc <= '0;
                S_WAIT: begin
                    if (sys_fail || w_to) r_job_fail <= 1'b1;
                    if (w_to) r_timeout <= 1'b1;
                    else if (r_cyc != TW'(TIMEOUT - 1)) r_cyc <= r_cyc + 1'b1;
                end
                S_UNLOAD: begin
                    if (w_rd_issue) begin
                        if (w_rd_last) r_rd_done <= 1'b1;
                        else           r_rd_cnt  <= r_rd_cnt + 1'b1;
                    end
                    if (w_pop_last) r_job_ok <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    skid_fifo2 #(.W(D + 1)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_pend),
        .i_data  ({r_rd_last_pend, sys_data_out}),
        .i_pop   (out_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_cnt)
    );

    assign in_ready    = (r_state == S_LOAD);
    assign sys_wr_en   = w_beat;
    assign sys_wr_addr = r_wr_cnt;
    assign sys_data_in = w_beat ? in_data : '0;
    assign sys_start   = (r_state == S_START);
    assign sys_rd_en   = w_rd_issue;
    assign sys_rd_addr = r_rd_cnt;
    assign out_valid   = w_fifo_valid;
    assign out_data    = w_fifo_data[D-1:0];
    assign out_last    = w_fifo_valid && w_fifo_data[D];
    assign busy        = (r_state != S_IDLE);
    assign job_ok      = r_job_ok;
    assign job_fail    = r_job_fail;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_systemizer_driver.sv
// Scoreboard bench for systemizer_driver with a behavioural systemizer memory model.
module tb_systemizer_driver;

    localparam int N = 20, M = 1, L = 40, K = 80, TO = 64;
    localparam int D = 20, WORDS = 160, AW = 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          job_start = 1'b0, in_valid = 1'b0;
    logic [D-1:0]  in_data = '0;
    logic          in_ready, sys_start, sys_wr_en, sys_rd_en;
    logic [AW-1:0] sys_wr_addr, sys_rd_addr;
    logic [D-1:0]  sys_data_in, out_data;
    logic [D-1:0]  sys_data_out = '0;
    logic          sys_success = 1'b0, sys_fail = 1'b0;
    logic          out_valid, out_last, busy, job_ok, job_fail, timeout;
    logic          out_ready = 1'b1;
    logic          rnd_ready = 1'b0;

    systemizer_driver #(.N(N), .M(M), .L(L), .K(K), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .job_start(job_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sys_start(sys_start), .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr),
        .sys_data_in(sys_data_in), .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr),
        .sys_data_out(sys_data_out), .sys_success(sys_success), .sys_fail(sys_fail),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .job_ok(job_ok), .job_fail(job_fail),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Systemizer memory model and monitors
    logic [D-1:0]  mem [WORDS];
    logic [D:0]    exp_q [$];
    int            wr_total = 0, rd_total = 0, pop_total = 0, start_total = 0;
    int            start_cyc = 0, last_wr_cyc = 0, wr_base = 0;
    logic          rd_pend_n = 1'b0;
    logic [AW-1:0] rd_addr_n = '0;

    always @(negedge clk) begin
        logic [D:0] e;
        if (sys_wr_en) begin
            chk("wr_addr", 128'(sys_wr_addr), 128'(wr_total - wr_base));
            mem[sys_wr_addr] = sys_data_in;
            wr_total++;
            last_wr_cyc = cyc;
        end
        if (sys_wr_en && sys_rd_en) chk("wr_rd_overlap", 128'(1), 128'(0));
        if (sys_start) begin
            start_total++;
            start_cyc = cyc;
        end
        rd_pend_n = sys_rd_en;
        rd_addr_n = sys_rd_addr;
        if (sys_rd_en) rd_total++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_extra_word", 128'({out_last, out_data}), 128'(0));
            else begin
                e = exp_q.pop_front();
                chk("out_word", 128'({out_last, out_data}), 128'(e));
            end
            pop_total++;
        end
    end

    always @(posedge clk) begin
        #1;
        sys_data_out = rd_pend_n ? mem[rd_addr_n] : '0;
        out_ready    = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [D-1:0] dval(input int seed, input int i);
        logic [31:0] t;
        t = 32'(i) * 32'd40503 + 32'(seed) * 32'd977 + 32'd5;
        return t[D-1:0] ^ t[31:12];
    endfunction

    int s_before, rd_base, pop_base;

    // Accepts a job and streams all words; leaves the bench in the first WAIT cycle.
    task automatic run_load(input int seed, input bit expect_out);
        int g;
        wr_base  = wr_total;
        rd_base  = rd_total;
        pop_base = pop_total;
        s_before = start_total;
        job_start = 1'b1;
        tick(1);
        job_start = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            in_valid = 1'b1;
            in_data  = dval(seed, i);
            if (expect_out) exp_q.push_back({(i == WORDS - 1), in_data});
            g = 0;
            @(negedge clk);
            while (!in_ready && g < 50) begin
                g++;
                @(negedge clk);
            end
            if (g >= 50) chk("load_ready_bound", 128'(0), 128'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        g = 0;
        while (start_total == s_before && g < 10) begin
            g++;
            tick(1);
        end
        chk("write_count", 128'(wr_total - wr_base), 128'(WORDS));
        chk("start_once", 128'(start_total - s_before), 128'(1));
        chk("start_after_last_write", 128'(start_cyc), 128'(last_wr_cyc + 1));
    endtask

    task automatic pulse_success();
        sys_success = 1'b1;
        tick(1);
        sys_success = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!job_ok && k < bound);
        if (k >= bound) chk("done_bound", 128'(0), 128'(1));
    endtask

    task automatic check_job_ok();
        chk("job_flags", 128'({job_ok, job_fail, timeout}), 128'(3'b100));
        chk("pop_count", 128'(pop_total - pop_base), 128'(WORDS));
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        chk("read_count", 128'(rd_total - rd_base), 128'(WORDS));
    endtask

    logic [127:0] all_out;
    assign all_out = {in_ready, sys_start, sys_wr_en, sys_wr_addr, sys_data_in, sys_rd_en,
                      sys_rd_addr, out_valid, out_data, out_last, busy, job_ok, job_fail, timeout};

    initial begin
        int k, rd_snap;
        // Reset state
        @(negedge clk);
        chk("reset_outputs", all_out, 128'(0));
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Full job, out_ready high: exact completion latency from the success pulse
        run_load(1, 1'b1);
        tick(49);
        pulse_success();
        wait_done(1000, k);
        chk("unload_latency", 128'(k), 128'(163));
        check_job_ok();
        tick(2);
        chk("idle_after_ok", 128'({busy, job_ok}), 128'(2'b01));

        // Completion pulses outside WAIT are ignored
        sys_success = 1'b1;
        sys_fail    = 1'b1;
        tick(1);
        sys_success = 1'b0;
        sys_fail    = 1'b0;
        @(negedge clk);
        chk("pulses_in_idle", 128'({busy, job_ok, job_fail}), 128'(3'b010));

        // Failure at WAIT cycle 10, coinciding with success: fail wins
        run_load(2, 1'b0);
        tick(10);
        sys_fail    = 1'b1;
        sys_success = 1'b1;
        tick(1);
        sys_fail    = 1'b0;
        sys_success = 1'b0;
        @(negedge clk);
        chk("fail_finish", 128'({busy, job_ok, job_fail, timeout}), 128'(4'b1010));
        tick(1);
        @(negedge clk);
        chk("fail_idle", 128'({busy, job_fail}), 128'(2'b01));
        chk("fail_no_reads", 128'(rd_total - rd_base), 128'(0));

        // Timeout, with a job_start issued mid-WAIT that must be ignored
        run_load(3, 1'b0);
        tick(4);
        job_start = 1'b1;
        tick(1);
        job_start = 1'b0;
        tick(58);
        @(negedge clk);
        chk("timeout_not_early", 128'({job_fail, timeout}), 128'(2'b00));
        tick(1);
        @(negedge clk);
        chk("timeout_flags", 128'({job_fail, timeout, job_ok}), 128'(3'b110));
        tick(2);
        chk("timeout_idle", 128'({busy, rd_total - rd_base}), 128'(0));

        // Random 30% out_ready: order and completeness
        rnd_ready = 1'b1;
        run_load(4, 1'b1);
        tick(5);
        pulse_success();
        wait_done(5000, k);
        check_job_ok();
        rnd_ready = 1'b0;
        tick(3);

        // Reset during UNLOAD at word 80
        run_load(5, 1'b1);
        tick(2);
        pulse_success();
        k = 0;
        while ((pop_total - pop_base) < 80 && k < 500) begin
            k++;
            tick(1);
        end
        chk("reached_word80", 128'(pop_total - pop_base >= 80), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("reset_midjob_outputs", all_out, 128'(0));
        exp_q.delete();
        rd_snap = rd_total;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("no_access_after_reset", 128'({rd_total - rd_snap, busy}), 128'(0));

        // Job after reset completes normally
        run_load(6, 1'b1);
        tick(20);
        pulse_success();
        wait_done(1000, k);
        chk("post_reset_latency", 128'(k), 128'(163));
        check_job_ok();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/systemizer_driver.md
SYSTEMIZER_DRIVER -- requirements
Module: systemizer_driver

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): N, 20, words per memory column; M, 1, bits per element; L, 200, matrix rows; K, 400, matrix columns; TIMEOUT, 2**20, maximum cycles in WAIT.
REQ-002 The module SHALL derive localparams WORDS = L*K/N and AW = `CLOG2(WORDS), where D = N*M is the word width.
REQ-003 The module SHALL have exactly these ports (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  job_start  in  1  one-cycle pulse that begins a job; ignored unless the block is in IDLE.
  in_valid / in_ready  in / out  1 / 1  matrix input stream handshake.
  in_data  in  D  matrix input word, column-major, word 0 first.
  sys_start  out  1  one-cycle start pulse to the systemizer.
  sys_wr_en  out  1  systemizer memory write enable.
  sys_wr_addr  out  AW  systemizer memory write address.
  sys_data_in  out  D  systemizer memory write data.
  sys_rd_en  out  1  systemizer memory read enable.
  sys_rd_addr  out  AW  systemizer memory read address.
  sys_data_out  in  D  systemizer read data, valid one cycle after sys_rd_en.
  sys_success / sys_fail  in / in  1 / 1  systemizer completion pulses.
  out_valid / out_ready  out / in  1 / 1  result output stream handshake.
  out_data  out  D  result word.
  out_last  out  1  marks word WORDS-1.
  busy  out  1  high in every state except IDLE.
  job_ok / job_fail  out / out  1 / 1  sticky job status.
  timeout  out  1  sticky; set only together with job_fail.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, START, WAIT, UNLOAD and FINISH.
REQ-005 IDLE with job_start SHALL go to LOAD and clear job_ok, job_fail, timeout and all counters.
REQ-006 In LOAD, in_ready SHALL be 1, and each in_valid&&in_ready beat SHALL produce sys_wr_en=1 in the same cycle, with sys_wr_addr equal to the write counter and sys_data_in equal to in_data; the counter then increments.
REQ-007 The beat at address WORDS-1 SHALL move the FSM to START; in_ready SHALL be 0 in all other states.
REQ-008 START SHALL assert sys_start for exactly one cycle and then enter WAIT with the cycle counter at 0.
REQ-009 In WAIT, sys_success SHALL go to UNLOAD; sys_fail SHALL set job_fail and go to FINISH; if both arrive in the same cycle, sys_fail SHALL win.
REQ-010 In WAIT, the cycle counter reaching TIMEOUT-1 without a completion pulse SHALL set job_fail and timeout and go to FINISH.
REQ-011 sys_success and sys_fail outside WAIT SHALL be ignored.
REQ-012 In UNLOAD, the block SHALL issue sys_rd_en with incrementing sys_rd_addr from 0 to WORDS-1.
REQ-013 Returned data SHALL be captured one cycle later into a 2-entry output FIFO.
REQ-014 A read SHALL be issued only if FIFO occupancy plus in-flight reads is below 2, so no data is lost under any out_ready pattern.
REQ-015 out_valid SHALL equal FIFO not-empty; out_data and out_last SHALL come from the FIFO head; with out_ready held high, throughput SHALL be 1 word/cycle after a 2-cycle initial latency.
REQ-016 Popping the word with out_last SHALL set job_ok and go to FINISH.
REQ-017 FINISH SHALL last one cycle and then go to IDLE; job_ok, job_fail and timeout SHALL hold until the next accepted job_start.
REQ-018 sys_wr_en and sys_rd_en SHALL never be asserted in the same cycle.
REQ-019 Counters SHALL be AW bits wide and SHALL not wrap during a job.
REQ-020 job_start while busy SHALL have no effect.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, empty the FIFO, and clear all counters.
REQ-022 During reset, every output SHALL be 0: in_ready, sys_*, out_valid, out_last, busy, job_ok, job_fail, timeout and all data/address buses.
REQ-023 Reset during any state SHALL abort the job with no further systemizer access; the first valid job_start after rst_n rises SHALL be accepted.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding and the WORDS/AW derivation function, for reuse by the systemizer and the key-generation top level.
REQ-025 The 2-entry output FIFO SHALL be a sub-module, skid_fifo2, parameterised by D+1 bits (data plus the last flag).

Verification
Use N=20, M=1, L=40, K=80, so WORDS=160 and AW=8.
REQ-026 Streaming 160 words with in_valid held high -> 160 writes at addresses 0..159, and sys_start fires exactly once, one cycle after the last write.
REQ-027 Model success at 50 cycles after start with out_ready=1 -> 160 output words equal the model memory, out_last on word 159, and job_ok=1.
REQ-028 Model sys_fail at cycle 10 of WAIT -> job_fail=1, no sys_rd_en ever asserted, FSM back in IDLE 2 cycles later.
REQ-029 TIMEOUT=64 and no completion pulse -> job_fail=1 and timeout=1 exactly 64 cycles after entering WAIT.
REQ-030 Random out_ready at 30% duty -> all 160 words appear in order with no loss or duplication, and the FIFO never overflows.
REQ-031 rst_n low during UNLOAD at word 80 -> all outputs 0 immediately, and a following job completes correctly.
